// File: rtl/quadrature_step_decoder_pkg.sv
// Gray state and direction constants plus the quadrature transition decoder.
// Both the decoder top and its bench-facing users import this package.
package qdec_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {NONE, UP, DOWN, ILLEGAL} qdec_res_t;

  // Successor of a state in the forward (count-up) direction.
  function automatic logic [1:0] qdec_next_fwd(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      QS_00:   n = QS_01;
      QS_01:   n = QS_11;
      QS_11:   n = QS_10;
      default: n = QS_00;
    endcase
    return n;
  endfunction

  function automatic qdec_res_t qdec_decode(input logic [1:0] prev, input logic [1:0] cur);
    qdec_res_t res;
    if (prev == cur)
      res = NONE;
    else if ((prev ^ cur) == 2'b11)
      res = ILLEGAL;
    else if (cur == qdec_next_fwd(prev))
      res = UP;
    else
      res = DOWN;
    return res;
  endfunction

endpackage

// File: rtl/quadrature_step_decoder_input_filter.sv
// One-bit 2-flop synchronizer with optional glitch filter (QDEC_GLITCH_FILTER_EN).
// Latency 2 cycles, or 2+FILTER_LEN when filtered; vld marks q as a real sample.
module quad_input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clock,
  input  logic preset,
  input  logic din,
  output logic q,
  output logic vld
);

  logic       sync1;
  logic       sync2;
  logic [1:0] fill;

  always_ff @(posedge clock or posedge preset) begin
    if (preset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      fill  <= 2'b00;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
    end
  end

  // Lengths below 1 are not meaningful; no hardware is generated for this check.
  if (FILTER_LEN < 1) begin : g_filter_len_below_one
  end

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int CW = (FILTER_LEN < 1) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((FILTER_LEN < 1) ? 0 : FILTER_LEN - 1);

  logic [CW-1:0] cnt;
  logic          filt;
  logic          filt_vld;

  // The first synchronized sample seeds the output so start-up is not seen as a change.
  always_ff @(posedge clock or posedge preset) begin
    if (preset) begin
      cnt      <= '0;
      filt     <= 1'b0;
      filt_vld <= 1'b0;
    end else if (!filt_vld) begin
      if (fill[1]) begin
        filt     <= sync2;
        filt_vld <= 1'b1;
      end
    end else if (sync2 == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      filt <= sync2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign q   = filt;
  assign vld = filt_vld;
`else
  assign q   = sync2;
  assign vld = fill[1];
`endif

endmodule

// File: rtl/quadrature_step_decoder.sv
// Quadrature A/B/index decoder: registered step, updown, load and sticky err for an up/down counter.
// Latency 3 cycles (2+FILTER_LEN+1 with QDEC_GLITCH_FILTER_EN); no backpressure, one step per cycle max.
module quadrature_step_decoder
  import qdec_pkg::*;
#(
  parameter int BITS        = 2,
  parameter int INDEX_VALUE = 0,
  parameter int FILTER_LEN  = 4,
  parameter int X1_MODE     = 0
) (
  input  logic            clock,
  input  logic            preset,
  input  logic            enc_a,
  input  logic            enc_b,
  input  logic            enc_idx,
  input  logic            err_clr,
  output logic            step,
  output logic            updown,
  output logic            load,
  output logic [BITS-1:0] load_data,
  output logic            err
);

  logic a_f, b_f, idx_f;
  logic a_vld, b_vld, idx_vld;

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clock(clock), .preset(preset), .din(enc_a), .q(a_f), .vld(a_vld)
  );
  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clock(clock), .preset(preset), .din(enc_b), .q(b_f), .vld(b_vld)
  );
  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_idx (
    .clock(clock), .preset(preset), .din(enc_idx), .q(idx_f), .vld(idx_vld)
  );

  logic [1:0] cur;
  logic [1:0] prev;
  logic       primed;
  logic       idx_prev;
  logic       in_vld;

  assign cur    = {a_f, b_f};
  assign in_vld = a_vld & b_vld & idx_vld;

  qdec_res_t dec;
  logic      step_nxt;
  logic      updown_nxt;
  logic      load_nxt;
  logic      err_nxt;

  always_comb begin
    dec        = primed ? qdec_decode(prev, cur) : NONE;
    step_nxt   = 1'b0;
    updown_nxt = updown;
    load_nxt   = 1'b0;
    // A new illegal edge overrides a simultaneous clear.
    err_nxt    = err & ~err_clr;
    case (dec)
      UP: begin
        if ((X1_MODE == 0) || ((prev == QS_10) && (cur == QS_00))) begin
          step_nxt   = 1'b1;
          updown_nxt = DIR_UP;
        end
      end
      DOWN: begin
        if ((X1_MODE == 0) || ((prev == QS_00) && (cur == QS_10))) begin
          step_nxt   = 1'b1;
          updown_nxt = DIR_DN;
        end
      end
      ILLEGAL: err_nxt = 1'b1;
      default: ;
    endcase
    if (primed && idx_f && !idx_prev && (cur == QS_00))
      load_nxt = 1'b1;
  end

  always_ff @(posedge clock or posedge preset) begin
    if (preset) begin
      prev      <= QS_00;
      idx_prev  <= 1'b0;
      primed    <= 1'b0;
      step      <= 1'b0;
      updown    <= DIR_UP;
      load      <= 1'b0;
      err       <= 1'b0;
      load_data <= BITS'(INDEX_VALUE);
    end else begin
      // The first real sample only primes history; decode starts on the next one.
      if (primed || in_vld) begin
        prev     <= cur;
        idx_prev <= idx_f;
      end
      if (in_vld)
        primed <= 1'b1;
      step      <= step_nxt;
      updown    <= updown_nxt;
      load      <= load_nxt;
      err       <= err_nxt;
      load_data <= BITS'(INDEX_VALUE);
    end
  end

endmodule
